hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects and
// data-memory wait handling with timeout and statistics counters.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pc_src,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wcnt;
  logic [7:0] wcnt_nx;

  logic taken;
  logic load_use;
  logic mem_stall;
  logic freeze;
  logic timeout;
  logic eval;
  logic redirect;
  logic lu_stall;

  always_comb begin
    taken     = exmem_branch & exmem_zero;
    load_use  = idex_memread & (idex_rd != 5'd0) &
                ((idex_rd == id_rs1) | (idex_rd == id_rs2));
    mem_stall = mem_req & ~mem_ready;
    timeout   = (state == MEM_WAIT) & ~mem_ready & (wcnt == MAX_W);
    freeze    = 1'b0;
    eval      = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        freeze = mem_stall;
        eval   = ~mem_stall;
      end
      default: begin
        freeze = ~mem_ready & ~timeout;
        eval   = mem_ready;
      end
    endcase
    redirect = eval & taken;
    lu_stall = eval & ~taken & load_use;
  end

  // Reset forces every enable low so nothing advances while held.
  always_comb begin
    pc_write     = ~reset & ~freeze & ~lu_stall;
    ifid_write   = ~reset & ~freeze & ~lu_stall;
    idex_write   = ~reset & ~freeze;
    exmem_hold   = ~reset & freeze;
    memwb_bubble = ~reset & freeze;
    idex_bubble  = ~reset & lu_stall;
    ifid_flush   = ~reset & redirect;
    idex_flush   = ~reset & redirect;
    exmem_flush  = ~reset & redirect;
    pc_src       = ~reset & redirect;
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          wcnt_nx  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || timeout) begin
          state_nx = RUN;
          wcnt_nx  = 8'd0;
        end else begin
          wcnt_nx = wcnt + 8'd1;
        end
      end
      default: begin
        state_nx = RUN;
        wcnt_nx  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      wcnt         <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_count  <= 8'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (timeout)
        mem_timeout <= 1'b1;
      if (!pc_write && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (redirect && flush_count != 8'hFF)
        flush_count <= flush_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, idex_rd;
  logic        idex_memread, exmem_branch, exmem_zero;
  logic        mem_req, mem_ready;
  logic        pc_write, ifid_write, idex_write, exmem_hold;
  logic        memwb_bubble, idex_bubble;
  logic        ifid_flush, idex_flush, exmem_flush, pc_src;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .exmem_hold(exmem_hold),
    .memwb_bubble(memwb_bubble), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_src(pc_src),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {pc_w, ifid_w, idex_w, hold, memwb_bub, idex_bub, 3 flushes, pc_src}
  localparam logic [9:0] RST = 10'b000_00_0_000_0;
  localparam logic [9:0] DEF = 10'b111_00_0_000_0;
  localparam logic [9:0] MST = 10'b000_11_0_000_0;
  localparam logic [9:0] LU  = 10'b001_00_1_000_0;
  localparam logic [9:0] TK  = 10'b111_00_0_111_1;

  typedef struct {
    string       name;
    logic [9:0]  ctl;
    logic [15:0] stall;
    logic [7:0]  flush;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] ctl;
      e = q.pop_front();
      ctl = {pc_write, ifid_write, idex_write, exmem_hold, memwb_bubble,
             idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_src};
      vectors++;
      if (ctl !== e.ctl || stall_cycles !== e.stall ||
          flush_count !== e.flush || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL %s: got ctl=%b stall=%0d flush=%0d to=%b, want ctl=%b stall=%0d flush=%0d to=%b",
                 e.name, ctl, stall_cycles, flush_count, mem_timeout,
                 e.ctl, e.stall, e.flush, e.to);
      end
    end
  end

  task automatic step(
    input string      name,
    input logic       rst,
    input logic [4:0] rs1, rs2, rd,
    input logic       mrd, br, z, req, rdy,
    input logic [9:0] ctl,
    input int         st, fl,
    input logic       to
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    id_rs1 = rs1; id_rs2 = rs2; idex_rd = rd;
    idex_memread = mrd; exmem_branch = br; exmem_zero = z;
    mem_req = req; mem_ready = rdy;
    e.name = name; e.ctl = ctl;
    e.stall = 16'(st); e.flush = 8'(fl); e.to = to;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    id_rs1 = 0; id_rs2 = 0; idex_rd = 0;
    idex_memread = 0; exmem_branch = 0; exmem_zero = 0;
    mem_req = 0; mem_ready = 0;
    //    name        rst rs1 rs2 rd mrd br z req rdy ctl  st fl to
    step("reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 0);
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0);
    step("lu_rs2",    0, 3, 5, 5, 1, 0, 0, 0, 0, LU,  0, 0, 0);
    step("lu_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 0, 0);
    step("load_x0",   0, 0, 4, 0, 1, 0, 0, 0, 0, DEF, 1, 0, 0);
    step("lu_rs1",    0, 7, 2, 7, 1, 0, 0, 0, 0, LU,  1, 0, 0);
    step("idle2",     0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2, 0, 0);
    step("mw_1",      0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 2, 0, 0);
    step("mw_2",      0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 3, 0, 0);
    step("mw_3",      0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 4, 0, 0);
    step("mw_done",   0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 5, 0, 0);
    step("mw_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 5, 0, 0);
    step("mw_br_1",   0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 5, 0, 0);
    step("mw_br_rdy", 0, 0, 0, 0, 0, 1, 1, 1, 1, TK,  6, 0, 0);
    step("br_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 6, 1, 0);
    step("br_vs_lu",  0, 9, 0, 9, 1, 1, 1, 0, 0, TK,  6, 1, 0);
    step("bvl_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 6, 2, 0);
    step("nt_lu",     0, 0, 9, 9, 1, 1, 0, 0, 0, LU,  6, 2, 0);
    step("nt_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 7, 2, 0);
    step("ms_vs_br",  0, 0, 0, 0, 0, 1, 1, 1, 0, MST, 7, 2, 0);
    step("ms_br_rdy", 0, 0, 0, 0, 0, 1, 1, 1, 1, TK,  8, 2, 0);
    step("msb_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 8, 3, 0);
    step("to_w1",     0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 8, 3, 0);
    step("to_w2",     0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 9, 3, 0);
    step("to_w3",     0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 10, 3, 0);
    step("to_w4",     0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 11, 3, 0);
    step("to_fire",   0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 12, 3, 0);
    step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 12, 3, 1);
    step("to_stick2", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 12, 3, 1);
    step("rw_1",      0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 12, 3, 1);
    step("rw_2",      0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 13, 3, 1);
    step("rw_reset",  1, 0, 0, 0, 0, 0, 0, 1, 0, RST, 0, 0, 0);
    step("rw_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step("sat_br",  0, 0, 0, 0, 0, 1, 1, 0, 0, TK, 0,
           (i > 255) ? 255 : i, 0);
    step("sat_final", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 255, 0);
    for (int k = 0; k < 20 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
